// File: rtl/delay_sched.sv
// Runtime-programmable delay line with a reconfiguration sequencer that drains
// in-flight samples before switching delay. Optional counters: DELAY_SCHED_STATS_EN.
module delay_sched #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned MAX_DELAY  = 8,
    parameter int unsigned INIT_DELAY = 0,
    localparam int unsigned DW        = $clog2(MAX_DELAY + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DW-1:0]    cfg_delay,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic [DW-1:0]    cur_delay,
    output logic [DW-1:0]    occupancy,
    output logic             busy
`ifdef DELAY_SCHED_STATS_EN
    ,
    input  logic             stat_clr,
    output logic [31:0]      stat_in_cnt,
    output logic [31:0]      stat_out_cnt,
    output logic [15:0]      stat_reconf_cnt
`endif
);

    if (WIDTH < 1) begin : g_bad_width
        $error("delay_sched: WIDTH must be > 0");
    end
    if (MAX_DELAY < 1) begin : g_bad_max
        $error("delay_sched: MAX_DELAY must be >= 1");
    end
    if (INIT_DELAY > MAX_DELAY) begin : g_bad_init
        $error("delay_sched: INIT_DELAY must be <= MAX_DELAY");
    end

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    cur_q, cur_d;
    logic [DW-1:0]    pend_q, pend_d;
    logic [DW-1:0]    occ_q, occ_d;
    logic [WIDTH-1:0] stage_q [MAX_DELAY];
    logic [MAX_DELAY-1:0] v_q;

    logic             accept;
    logic             cfg_fire;
    logic             chain_live;
    logic             drain_done;
    logic             occ_inc;
    logic             occ_dec;
    logic             tap_v;
    logic [WIDTH-1:0] tap_data;

    assign in_ready   = (state_q == RUN);
    assign cfg_ready  = (state_q == RUN);
    assign busy       = (state_q == DRAIN);
    assign accept     = in_valid & in_ready;
    assign cfg_fire   = cfg_valid & cfg_ready;
    assign chain_live = (cur_q != '0);
    assign cur_delay  = cur_q;
    assign occupancy  = occ_q;

    // Tap select: stage D-1 carries a sample accepted exactly D cycles ago
    always_comb begin
        tap_v    = 1'b0;
        tap_data = '0;
        for (int j = 0; j < int'(MAX_DELAY); j++) begin
            if (cur_q == DW'(j + 1)) begin
                tap_v    = v_q[j];
                tap_data = stage_q[j];
            end
        end
    end

    assign out_valid = chain_live ? tap_v : accept;
    assign out_data  = chain_live ? tap_data : in_data;

    assign occ_inc = accept & chain_live;
    assign occ_dec = tap_v & chain_live;

    // Next-state, occupancy and delay switch-over
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        pend_d     = pend_q;
        occ_d      = occ_q;
        drain_done = 1'b0;

        if (occ_inc && !occ_dec) begin
            occ_d = occ_q + DW'(1);
        end else if (!occ_inc && occ_dec) begin
            occ_d = occ_q - DW'(1);
        end

        case (state_q)
            RUN: begin
                if (cfg_fire) begin
                    pend_d  = (cfg_delay > DW'(MAX_DELAY)) ? DW'(MAX_DELAY) : cfg_delay;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Leave on the edge where the last old-delay sample has exited
                if (occ_d == '0) begin
                    drain_done = 1'b1;
                    cur_d      = pend_q;
                    state_d    = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cur_q   <= DW'(INIT_DELAY);
            pend_q  <= '0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            pend_q  <= pend_d;
            occ_q   <= occ_d;
        end
    end

    // Free-running chain; valids are flushed on switch-over so stale taps never fire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < int'(MAX_DELAY); j++) begin
                stage_q[j] <= '0;
            end
            v_q <= '0;
        end else begin
            stage_q[0] <= in_data;
            for (int j = 1; j < int'(MAX_DELAY); j++) begin
                stage_q[j] <= stage_q[j-1];
            end
            if (drain_done) begin
                v_q <= '0;
            end else begin
                v_q[0] <= accept;
                for (int j = 1; j < int'(MAX_DELAY); j++) begin
                    v_q[j] <= v_q[j-1];
                end
            end
        end
    end

`ifdef DELAY_SCHED_STATS_EN
    // Wrapping event counters; synchronous clear takes priority over counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_in_cnt     <= '0;
            stat_out_cnt    <= '0;
            stat_reconf_cnt <= '0;
        end else if (stat_clr) begin
            stat_in_cnt     <= '0;
            stat_out_cnt    <= '0;
            stat_reconf_cnt <= '0;
        end else begin
            stat_in_cnt     <= stat_in_cnt + 32'(accept);
            stat_out_cnt    <= stat_out_cnt + 32'(out_valid);
            stat_reconf_cnt <= stat_reconf_cnt + 16'(cfg_fire);
        end
    end
`endif

endmodule

// File: tb/tb_delay_sched.sv
// Directed self-checking bench for delay_sched (default parameters).
module tb_delay_sched;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned MAXD  = 8;
    localparam int unsigned DW    = $clog2(MAXD + 1);

    logic             clk;
    logic             rst_n;
    logic [DW-1:0]    cfg_delay;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic [DW-1:0]    cur_delay;
    logic [DW-1:0]    occupancy;
    logic             busy;
`ifdef DELAY_SCHED_STATS_EN
    logic             stat_clr;
    logic [31:0]      stat_in_cnt;
    logic [31:0]      stat_out_cnt;
    logic [15:0]      stat_reconf_cnt;
`endif

    int checks = 0;
    int errors = 0;

    delay_sched #(.WIDTH(WIDTH), .MAX_DELAY(MAXD), .INIT_DELAY(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_delay (cfg_delay),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .cur_delay (cur_delay),
        .occupancy (occupancy),
        .busy      (busy)
`ifdef DELAY_SCHED_STATS_EN
        ,
        .stat_clr        (stat_clr),
        .stat_in_cnt     (stat_in_cnt),
        .stat_out_cnt    (stat_out_cnt),
        .stat_reconf_cnt (stat_reconf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int outs;
        int occ_exp3 [12];
        occ_exp3 = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1, 1, 0};

        rst_n     = 1'b1;
        cfg_delay = '0;
        cfg_valid = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
`ifdef DELAY_SCHED_STATS_EN
        stat_clr  = 1'b0;
`endif
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data",  32'(out_data),  0);
        chk("rst_busy",      32'(busy),      0);
        chk("rst_in_ready",  32'(in_ready),  1);
        chk("rst_cfg_ready", 32'(cfg_ready), 1);
        chk("rst_cur_delay", 32'(cur_delay), 0);
        chk("rst_occupancy", 32'(occupancy), 0);
        #9 rst_n = 1'b1;

        // Bypass at delay 0
        in_valid = 1'b1;
        in_data  = 16'h1234;
        #1;
        chk("byp_valid", 32'(out_valid), 1);
        chk("byp_data",  32'(out_data),  32'h1234);
        step();
        chk("byp_occ", 32'(occupancy), 0);
        in_valid = 1'b0;
        in_data  = '0;

        // Program delay 3 from idle: one busy cycle
        cfg_valid = 1'b1;
        cfg_delay = 4'd3;
        #1;
        chk("cfg3_ready", 32'(cfg_ready), 1);
        step();
        cfg_valid = 1'b0;
        #1;
        chk("cfg3_busy",     32'(busy),      1);
        chk("cfg3_in_ready", 32'(in_ready),  0);
        chk("cfg3_old_cur",  32'(cur_delay), 0);
        step();
        chk("cfg3_busy_end", 32'(busy),      0);
        chk("cfg3_cur",      32'(cur_delay), 3);

        // Five back-to-back samples at delay 3
        for (int c = 0; c < 10; c++) begin
            if (c > 0) step();
            in_valid = (c < 5);
            in_data  = (c < 5) ? 16'(c + 1) : 16'h0;
            #1;
            acc  = (c < 5) ? c : 5;
            outs = (c < 3) ? 0 : ((c - 3 > 5) ? 5 : c - 3);
            chk("d3_valid", 32'(out_valid), 32'((c >= 3) && (c < 8)));
            if (c >= 3 && c < 8) chk("d3_data", 32'(out_data), 32'(c - 2));
            chk("d3_occ", 32'(occupancy), 32'(acc - outs));
        end

        // Move to delay 4
        step();
        cfg_valid = 1'b1;
        cfg_delay = 4'd4;
        step();
        cfg_valid = 1'b0;
        #1;
        chk("cfg4_busy", 32'(busy), 1);
        step();
        chk("cfg4_cur", 32'(cur_delay), 4);

        // Four in flight at delay 4, reconfigure to 2 while the last is accepted
        for (int c = 0; c < 12; c++) begin
            if (c > 0) step();
            in_valid  = (c <= 8);
            in_data   = (c < 4) ? 16'(16'h10 + c) : ((c < 8) ? 16'h20 : 16'h21);
            cfg_valid = (c == 3);
            cfg_delay = 4'd2;
            #1;
            chk("d42_in_ready", 32'(in_ready), 32'(!((c >= 4) && (c <= 7))));
            chk("d42_busy",     32'(busy),     32'((c >= 4) && (c <= 7)));
            chk("d42_cur",      32'(cur_delay), (c <= 7) ? 32'd4 : 32'd2);
            chk("d42_valid",    32'(out_valid), 32'(((c >= 4) && (c <= 7)) || (c == 10)));
            if (c >= 4 && c <= 7) chk("d42_data", 32'(out_data), 32'(16'h10 + c - 4));
            if (c == 10) chk("d42_new_data", 32'(out_data), 32'h21);
            chk("d42_occ", 32'(occupancy), 32'(occ_exp3[c]));
        end

        // Over-range request clamps to MAX_DELAY
        step();
        in_valid  = 1'b0;
        cfg_valid = 1'b1;
        cfg_delay = 4'd15;
        step();
        cfg_valid = 1'b0;
        #1;
        chk("cfg15_busy", 32'(busy), 1);
        step();
        chk("cfg15_cur", 32'(cur_delay), 8);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) step();
            in_valid = (c == 0);
            in_data  = 16'hABCD;
            #1;
            chk("d8_valid", 32'(out_valid), 32'(c == 8));
            if (c == 8) chk("d8_data", 32'(out_data), 32'hABCD);
        end

        // Reset in the middle of a drain with two samples in flight
        step();
        in_valid = 1'b1;
        in_data  = 16'h0055;
        step();
        in_data   = 16'h0066;
        cfg_valid = 1'b1;
        cfg_delay = 4'd2;
        step();
        in_valid  = 1'b0;
        cfg_valid = 1'b0;
        #1;
        chk("mid_busy", 32'(busy),      1);
        chk("mid_occ",  32'(occupancy), 2);
        step();
        rst_n = 1'b0;
        #1;
        chk("mrst_valid",     32'(out_valid), 0);
        chk("mrst_busy",      32'(busy),      0);
        chk("mrst_cur",       32'(cur_delay), 0);
        chk("mrst_cfg_ready", 32'(cfg_ready), 1);
        chk("mrst_occ",       32'(occupancy), 0);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            chk("post_valid", 32'(out_valid), 0);
            chk("post_busy",  32'(busy),      0);
        end

`ifdef DELAY_SCHED_STATS_EN
        // Two reconfigurations, ten accepts, then a clear that beats an increment
        cfg_valid = 1'b1;
        cfg_delay = 4'd0;
        step();
        cfg_valid = 1'b0;
        step();
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        step();
        chk("st_cur0", 32'(cur_delay), 0);
        in_valid = 1'b1;
        in_data  = 16'h0777;
        for (int c = 0; c < 10; c++) step();
        stat_clr = 1'b1;
        #1;
        chk("st_in",     stat_in_cnt,           10);
        chk("st_out",    stat_out_cnt,          10);
        chk("st_reconf", 32'(stat_reconf_cnt),  2);
        step();
        stat_clr = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("st_in_clr",     stat_in_cnt,          0);
        chk("st_out_clr",    stat_out_cnt,         0);
        chk("st_reconf_clr", 32'(stat_reconf_cnt), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
